acs_path_metric: RTL

//   Add-compare-select stage of the Viterbi decoder, directly downstream of the 16-bit symbol

---
 rtl/acs_path_metric.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/acs_path_metric.sv
// acs_path_metric
//   Add-compare-select stage of a 4-state Viterbi decoder (K=3, rate 1/2,
//   generators g0=7, g1=5 octal). A block of 8 hard-decision bit pairs is
//   captured in one handshake. One pair is processed per cycle, and one
//   4-bit survivor-decision word is produced per trellis step. Path metrics
//   carry across blocks unless frame_start is captured with the block.
//
// Parameters
//   PM_W     path-metric width (4..12), unsigned, saturating
//   INIT_PM  reset/reinit metric for states 1..3 (state 0 starts at 0)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   frame_start         captured with the block: reinit metrics before step 0
//   in_valid/in_ready   block capture handshake
//   bit_pair_0..7       received pairs, [1]=g0 symbol, [0]=g1 symbol, 0 oldest
//   dec_valid           dec/step/pm0..pm3 valid
//   dec                 dec[s]=1: survivor of state s came from odd predecessor
//   step                trellis step within block, 0..7
//   pm0..pm3            normalised path metrics after this step
//   block_done          pulses with dec_valid on step 7
//
// Optional feature (macro ACS_BEST_STATE_EN)
//   best_state          lowest-index state whose normalised metric is 0
//   best_pm             that state's metric before normalisation
module acs_path_metric #(
  parameter int unsigned PM_W    = 6,
  parameter int unsigned INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      bit_pair_0,
  input  logic [1:0]      bit_pair_1,
  input  logic [1:0]      bit_pair_2,
  input  logic [1:0]      bit_pair_3,
  input  logic [1:0]      bit_pair_4,
  input  logic [1:0]      bit_pair_5,
  input  logic [1:0]      bit_pair_6,
  input  logic [1:0]      bit_pair_7,
  output logic            dec_valid,
  output logic [3:0]      dec,
  output logic [2:0]      step,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3,
  output logic            block_done
`ifdef ACS_BEST_STATE_EN
  ,
  output logic [1:0]      best_state,
  output logic [PM_W-1:0] best_pm
`endif
);

  localparam logic [0:0]      S_IDLE  = 1'b0;
  localparam logic [0:0]      S_RUN   = 1'b1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

  logic [0:0]      r_fsm;
  logic [2:0]      r_cnt;
  logic            r_fs;
  logic [1:0]      r_pairs [8];
  logic [PM_W-1:0] r_pm    [4];
  logic            r_dec_valid;
  logic [3:0]      r_dec;
  logic [2:0]      r_step;
  logic            r_block_done;

  logic            w_capture;
  logic [1:0]      w_rx;
  logic [PM_W-1:0] w_base [4];
  logic [PM_W-1:0] w_new  [4];
  logic [PM_W-1:0] w_norm [4];
  logic [PM_W-1:0] w_min;
  logic [1:0]      w_best;
  logic [3:0]      w_dec;

  // Hamming distance between a received pair and an expected symbol.
  function automatic logic [1:0] bm(input logic [1:0] r, input logic [1:0] e);
    logic [1:0] x;
    x = r ^ e;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Encoder output for state p={s1,s0} and input u: {u^s1^s0, u^s0}.
  function automatic logic [1:0] exp_sym(input logic u, input logic [1:0] p);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  // A capture is possible while idle or while the last step of the
  // current block is being computed, which keeps blocks back-to-back.
  assign in_ready  = (r_fsm == S_IDLE) || ((r_fsm == S_RUN) && (r_cnt == 3'd7));
  assign w_capture = in_valid && in_ready;
  assign w_rx      = r_pairs[r_cnt];

  // Step 0 of a frame_start block starts from the reinit metrics instead
  // of whatever the previous block left behind.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      w_base[i] = r_pm[i];
      if ((r_cnt == 3'd0) && r_fs) begin
        w_base[i] = (i == 0) ? '0 : PM_INIT;
      end
    end
  end

  // Next state n={u,s1}: predecessors {n[0],0} and {n[0],1}, input u=n[1].
  for (genvar n = 0; n < 4; n++) begin : g_acs
    localparam logic [1:0] PA = 2'((n % 2) * 2);
    localparam logic [1:0] PB = 2'((n % 2) * 2 + 1);
    localparam logic       U  = 1'(n / 2);
    logic [PM_W-1:0] w_cand_a;
    logic [PM_W-1:0] w_cand_b;
    assign w_cand_a = sat_add(w_base[PA], bm(w_rx, exp_sym(U, PA)));
    assign w_cand_b = sat_add(w_base[PB], bm(w_rx, exp_sym(U, PB)));
    // Ties go to the even predecessor.
    assign w_dec[n] = (w_cand_b < w_cand_a);
    assign w_new[n] = w_dec[n] ? w_cand_b : w_cand_a;
  end

  // Strict compare keeps the lowest-index state on equal metrics.
  always_comb begin
    w_min  = w_new[0];
    w_best = 2'd0;
    for (int unsigned i = 1; i < 4; i++) begin
      if (w_new[i] < w_min) begin
        w_min  = w_new[i];
        w_best = 2'(i);
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      w_norm[i] = w_new[i] - w_min;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm        <= S_IDLE;
      r_cnt        <= '0;
      r_fs         <= 1'b0;
      r_dec_valid  <= 1'b0;
      r_dec        <= '0;
      r_step       <= '0;
      r_block_done <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_pairs[i] <= '0;
      end
      r_pm[0] <= '0;
      r_pm[1] <= PM_INIT;
      r_pm[2] <= PM_INIT;
      r_pm[3] <= PM_INIT;
    end else begin
      r_dec_valid  <= 1'b0;
      r_block_done <= 1'b0;
      if (r_fsm == S_RUN) begin
        r_dec_valid  <= 1'b1;
        r_dec        <= w_dec;
        r_step       <= r_cnt;
        r_block_done <= (r_cnt == 3'd7);
        r_cnt        <= r_cnt + 3'd1;
        for (int unsigned i = 0; i < 4; i++) begin
          r_pm[i] <= w_norm[i];
        end
        if ((r_cnt == 3'd7) && !w_capture) begin
          r_fsm <= S_IDLE;
        end
      end
      if (w_capture) begin
        r_fsm      <= S_RUN;
        r_cnt      <= '0;
        r_fs       <= frame_start;
        r_pairs[0] <= bit_pair_0;
        r_pairs[1] <= bit_pair_1;
        r_pairs[2] <= bit_pair_2;
        r_pairs[3] <= bit_pair_3;
        r_pairs[4] <= bit_pair_4;
        r_pairs[5] <= bit_pair_5;
        r_pairs[6] <= bit_pair_6;
        r_pairs[7] <= bit_pair_7;
      end
    end
  end

`ifdef ACS_BEST_STATE_EN
  logic [1:0]      r_best_state;
  logic [PM_W-1:0] r_best_pm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_state <= '0;
      r_best_pm    <= '0;
    end else if (r_fsm == S_RUN) begin
      r_best_state <= w_best;
      r_best_pm    <= w_min;
    end
  end

  assign best_state = r_best_state;
  assign best_pm    = r_best_pm;
`endif

  assign dec_valid  = r_dec_valid;
  assign dec        = r_dec;
  assign step       = r_step;
  assign block_done = r_block_done;
  assign pm0        = r_pm[0];
  assign pm1        = r_pm[1];
  assign pm2        = r_pm[2];
  assign pm3        = r_pm[3];

endmodule
